// File: rtl/sd_bitstream_buffer.sv
// sd_bitstream_buffer: takes the SD/FAT32 reader's byte stream one 512-byte sector at a time.
// Bytes are packed MSB-first into 32-bit words and held in a two-sector ring buffer. Words go to
// the H.264 parser over a valid/ready handshake. eos is raised once the file has ended and the
// buffer is empty.
// Optional feature macro: SD_BUF_EOS_PAD_EN. When defined, a trailing partial word is
// zero-padded and emitted. Otherwise the trailing partial word is discarded.
module sd_bitstream_buffer #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic        clk_i,
    input  logic        rst_n,
    output logic        file_read_req,
    input  logic [7:0]  file_data,
    input  logic        file_data_valid,
    input  logic        file_reach_end,
    output logic [31:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        eos,
    output logic        ovf_err
);
    localparam int unsigned LvlW        = ADDR_W + 2;
    localparam int unsigned PtrW        = ADDR_W + 1;
    localparam int unsigned SectorWords = 128;

    typedef enum logic [1:0] {StIdle, StWait, StFlush, StEof} state_e;

    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic [9:0]      sec_cnt_q, sec_cnt_d;
    logic            eos_q, eos_d;
    logic            ovf_q, ovf_d;
    logic [LvlW-1:0] level_q, level_d;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;

    logic [1:0]      cnt_q, cnt_d;
    logic [23:0]     hold_q, hold_d;
    logic            wr_pend_q, wr_pend_d;
    logic [31:0]     wr_word_q, wr_word_d;

    logic [31:0]     mem_q [DEPTH_WORDS];
    logic [31:0]     rd_data_q;
    logic            rd_vld_q, rd_vld_d;
    logic [31:0]     dout_q, dout_d;
    logic            dout_valid_q, dout_valid_d;

    logic            pop, move, issue, commit, full, flush_go;
    logic [LvlW-1:0] ram_words, lvl_eff;

    // The read-data stage counts as RAM storage, so RAM + output register never exceed DEPTH+1.
    assign ram_words = level_q - LvlW'(dout_valid_q);
    assign full      = ram_words >= LvlW'(DEPTH_WORDS);
    assign commit    = wr_pend_q && !full;
    assign pop       = dout_valid_q && dout_ready;
    assign move      = rd_vld_q && (!dout_valid_q || pop);
    assign issue     = (wr_ptr_q != rd_ptr_q) && (!rd_vld_q || move);
    // A word still in the write pipeline already occupies space for request decisions.
    assign lvl_eff   = level_q + LvlW'(wr_pend_q);
    assign flush_go  = (state_q == StFlush) && !file_data_valid;

    // Request FSM next state, one-cycle request pulse, and sector byte counting.
    always_comb begin
        state_d   = state_q;
        req_d     = 1'b0;
        sec_cnt_d = sec_cnt_q;
        case (state_q)
            StIdle: begin
                if (file_reach_end) begin
                    state_d = StFlush;
                end else if (lvl_eff <= LvlW'(DEPTH_WORDS - SectorWords)) begin
                    req_d     = 1'b1;
                    sec_cnt_d = 10'd0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (file_data_valid) begin
                    if (sec_cnt_q == 10'd511) begin
                        state_d = StIdle;
                    end else begin
                        sec_cnt_d = sec_cnt_q + 10'd1;
                    end
                end else if (file_reach_end) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                // A stray byte in the same cycle is packed first; flush on the next quiet cycle.
                if (!file_data_valid) state_d = StEof;
            end
            StEof:   state_d = StEof;
            default: state_d = StIdle;
        endcase
    end

    // Byte packer: 4th byte completes a word; a flush optionally pads the partial word.
    always_comb begin
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        wr_pend_d = 1'b0;
        wr_word_d = wr_word_q;
        if (file_data_valid) begin
            if (cnt_q == 2'd3) begin
                wr_pend_d = 1'b1;
                wr_word_d = {hold_q, file_data};
                cnt_d     = 2'd0;
            end else begin
                hold_d = {hold_q[15:0], file_data};
                cnt_d  = cnt_q + 2'd1;
            end
        end else if (flush_go) begin
`ifdef SD_BUF_EOS_PAD_EN
            if (cnt_q != 2'd0) begin
                wr_pend_d = 1'b1;
                case (cnt_q)
                    2'd1:    wr_word_d = {hold_q[7:0], 24'h000000};
                    2'd2:    wr_word_d = {hold_q[15:0], 16'h0000};
                    default: wr_word_d = {hold_q, 8'h00};
                endcase
            end
`endif
            cnt_d  = 2'd0;
            hold_d = 24'h000000;
        end
    end

    // Show-ahead output: refill from the read stage when empty or being popped.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        rd_vld_d     = rd_vld_q;
        if (pop) dout_valid_d = 1'b0;
        if (move) begin
            dout_d       = rd_data_q;
            dout_valid_d = 1'b1;
            rd_vld_d     = 1'b0;
        end
        if (issue) rd_vld_d = 1'b1;
    end

    // Sticky status and level bookkeeping.
    always_comb begin
        level_d = level_q + LvlW'(commit) - LvlW'(pop);
        ovf_d   = ovf_q | (wr_pend_q && full);
        eos_d   = eos_q | ((state_q == StEof) && (level_q == '0) && !wr_pend_q);
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            req_q     <= 1'b0;
            sec_cnt_q <= 10'd0;
            eos_q     <= 1'b0;
            ovf_q     <= 1'b0;
            level_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            sec_cnt_q <= sec_cnt_d;
            eos_q     <= eos_d;
            ovf_q     <= ovf_d;
            level_q   <= level_d;
            wr_ptr_q  <= wr_ptr_q + PtrW'(commit);
            rd_ptr_q  <= rd_ptr_q + PtrW'(issue);
        end
    end

    // Packer and output registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= 2'd0;
            hold_q       <= 24'h000000;
            wr_pend_q    <= 1'b0;
            wr_word_q    <= 32'h0;
            rd_vld_q     <= 1'b0;
            dout_q       <= 32'h0;
            dout_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            wr_pend_q    <= wr_pend_d;
            wr_word_q    <= wr_word_d;
            rd_vld_q     <= rd_vld_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Ring RAM with synchronous write and synchronous read.
    always_ff @(posedge clk_i) begin
        if (commit) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_word_q;
        if (issue) rd_data_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
    end

    assign file_read_req = req_q;
    assign dout          = dout_q;
    assign dout_valid    = dout_valid_q;
    assign eos           = eos_q;
    assign ovf_err       = ovf_q;

endmodule
